// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue_pkg
//  Description : Shared CPU definitions used by the fetch queue. It holds
//                the opcode field width and the opcode encodings, including
//                the halt opcode that freezes instruction fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_queue_pkg;

    // Opcode field width. The opcode is taken from the instruction MSBs.
    localparam int OP_W = 4;

    // Opcode encodings
    localparam logic [OP_W-1:0] OPC_ADD = 4'b0000;
    localparam logic [OP_W-1:0] OPC_SUB = 4'b0001;
    localparam logic [OP_W-1:0] OPC_LD  = 4'b1000;
    localparam logic [OP_W-1:0] OPC_ST  = 4'b1001;
    localparam logic [OP_W-1:0] OPC_BR  = 4'b1100;
    localparam logic [OP_W-1:0] OPC_HLT = 4'b1111;

endpackage : fetch_queue_pkg
`default_nettype wire

// File: rtl/fetch_queue_storage.sv
`default_nettype none
// ============================================================================
//  Module      : fq_storage
//  Description : Register array of DEPTH x DW bits for the fetch queue. It
//                has one synchronous write port and one asynchronous
//                (combinational) read port. Reset clears every entry.
//  Ports       : clk, rst_n           - clock, async active-low reset
//                wr_en, wr_addr, wr_data - write port
//                rd_addr, rd_data     - asynchronous read port
//  Revision    : 1.0 - initial release
// ============================================================================
module fq_storage #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule : fq_storage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Instruction fetch buffer between instruction memory and
//                decode. It is a DEPTH-entry first-word-fall-through FIFO of
//                {instruction, PC+2} pairs with decode backpressure, a branch
//                flush, and a halt latch that stops pushes after a HLT.
//  Ports       : clk, rst_n                         - clock, async reset
//                push_valid_i/instr_i/pc_i/ready_o  - fetch side
//                pop_valid_o/instr_o/pc_o/ready_i   - decode side
//                flush_i                            - discard all contents
//                halted_o                           - HLT accepted, frozen
//                count_o                            - current occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int              WIDTH  = 16,
    parameter int              PC_W   = 16,
    parameter int              DEPTH  = 4,
    parameter int              OP_W   = fetch_queue_pkg::OP_W,
    parameter logic [OP_W-1:0] HLT_OP = OPC_HLT
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_valid_i,
    input  logic [WIDTH-1:0]           push_instr_i,
    input  logic [PC_W-1:0]            push_pc_i,
    output logic                       push_ready_o,
    output logic                       pop_valid_o,
    output logic [WIDTH-1:0]           pop_instr_o,
    output logic [PC_W-1:0]            pop_pc_o,
    input  logic                       pop_ready_i,
    input  logic                       flush_i,
    output logic                       halted_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int DW = WIDTH + PC_W;

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_halted;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_is_hlt;
    logic [DW-1:0] w_rd_data;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Ready depends on registered state only, so a full queue never
    // accepts a push alongside a pop in the same cycle.
    assign push_ready_o = !w_full && !r_halted;
    assign pop_valid_o  = !w_empty;

    assign w_push   = push_valid_i && push_ready_o && !flush_i;
    assign w_pop    = pop_valid_o && pop_ready_i && !flush_i;
    assign w_is_hlt = (push_instr_i[WIDTH-1 -: OP_W] == HLT_OP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_halted <= 1'b0;
        end else if (flush_i) begin
            // Storage is left as-is; an empty queue masks it on the outputs.
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_halted <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CW'(1);
            end
            if (w_push && w_is_hlt) begin
                r_halted <= 1'b1;
            end
        end
    end

    fq_storage #(
        .DEPTH (DEPTH),
        .DW    (DW),
        .AW    (AW)
    ) u_storage (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (w_push),
        .wr_addr (r_wr_ptr),
        .wr_data ({push_instr_i, push_pc_i}),
        .rd_addr (r_rd_ptr),
        .rd_data (w_rd_data)
    );

    // Stale storage after a flush must not leak out, so gate on empty.
    assign pop_instr_o = w_empty ? '0 : w_rd_data[DW-1 -: WIDTH];
    assign pop_pc_o    = w_empty ? '0 : w_rd_data[PC_W-1:0];
    assign halted_o    = r_halted;
    assign count_o     = r_count;

endmodule : fetch_queue
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Directed self-checking bench for fetch_queue (DEPTH=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int WIDTH = 16;
    localparam int PC_W  = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic             clk;
    logic             rst_n;
    logic             push_valid;
    logic [WIDTH-1:0] push_instr;
    logic [PC_W-1:0]  push_pc;
    logic             push_ready;
    logic             pop_valid;
    logic [WIDTH-1:0] pop_instr;
    logic [PC_W-1:0]  pop_pc;
    logic             pop_ready;
    logic             flush;
    logic             halted;
    logic [CW-1:0]    count;

    int n_cmp;
    int n_err;

    fetch_queue #(
        .WIDTH (WIDTH),
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_valid_i (push_valid),
        .push_instr_i (push_instr),
        .push_pc_i    (push_pc),
        .push_ready_o (push_ready),
        .pop_valid_o  (pop_valid),
        .pop_instr_o  (pop_instr),
        .pop_pc_o     (pop_pc),
        .pop_ready_i  (pop_ready),
        .flush_i      (flush),
        .halted_o     (halted),
        .count_o      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [15:0] instr, input logic [15:0] pc);
        push_valid = 1'b1;
        push_instr = instr;
        push_pc    = pc;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic pop1();
        pop_ready = 1'b1;
        tick();
        pop_ready = 1'b0;
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        push_valid = 1'b0;
        push_instr = '0;
        push_pc    = '0;
        pop_ready  = 1'b0;
        flush      = 1'b0;
        #12;
        check_eq("rst_push_ready", 32'(push_ready), 32'd1);
        check_eq("rst_pop_valid",  32'(pop_valid),  32'd0);
        check_eq("rst_pop_instr",  32'(pop_instr),  32'd0);
        check_eq("rst_pop_pc",     32'(pop_pc),     32'd0);
        check_eq("rst_halted",     32'(halted),     32'd0);
        check_eq("rst_count",      32'(count),      32'd0);
        rst_n = 1'b1;
        tick();

        // 1: single push, visible after one edge
        push1(16'h0123, 16'h0002);
        check_eq("t1_pop_valid", 32'(pop_valid), 32'd1);
        check_eq("t1_pop_instr", 32'(pop_instr), 32'h0123);
        check_eq("t1_pop_pc",    32'(pop_pc),    32'h0002);
        check_eq("t1_count",     32'(count),     32'd1);
        pop1();
        check_eq("t1_empty_valid", 32'(pop_valid), 32'd0);
        check_eq("t1_empty_instr", 32'(pop_instr), 32'd0);

        // 2: fill to DEPTH, refuse fifth, drain in order
        for (int i = 1; i <= 4; i++) begin
            push1(16'h1000 + 16'(i), 16'h0010 + 16'(2*i));
        end
        check_eq("t2_count_full",  32'(count),      32'd4);
        check_eq("t2_ready_full",  32'(push_ready), 32'd0);
        push1(16'h1005, 16'h001A);
        check_eq("t2_fifth_refused", 32'(count), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            check_eq("t2_drain_instr", 32'(pop_instr), 32'h1000 + 32'(i));
            check_eq("t2_drain_pc",    32'(pop_pc),    32'h0010 + 32'(2*i));
            pop1();
        end
        check_eq("t2_count_empty", 32'(count), 32'd0);

        // 3: steady push+pop with one entry held, across pointer wrap
        push1(16'h3000, 16'h3000);
        for (int k = 1; k <= 10; k++) begin
            push_valid = 1'b1;
            push_instr = 16'h3000 + 16'(k);
            push_pc    = 16'h3000 + 16'(k);
            pop_ready  = 1'b1;
            check_eq("t3_head", 32'(pop_instr), 32'h3000 + 32'(k-1));
            tick();
            check_eq("t3_count", 32'(count), 32'd1);
        end
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        check_eq("t3_last", 32'(pop_instr), 32'h300A);
        pop1();
        check_eq("t3_count_empty", 32'(count), 32'd0);

        // 4: HLT latches, further pushes ignored, HLT drains
        push1(16'h2000, 16'h0100);
        push1(16'hF000, 16'h0102);
        check_eq("t4_halted",     32'(halted),     32'd1);
        check_eq("t4_push_ready", 32'(push_ready), 32'd0);
        check_eq("t4_count",      32'(count),      32'd2);
        push1(16'h2222, 16'h0104);
        check_eq("t4_push_ignored", 32'(count), 32'd2);
        check_eq("t4_pop0", 32'(pop_instr), 32'h2000);
        pop1();
        check_eq("t4_pop1", 32'(pop_instr), 32'hF000);
        pop1();
        check_eq("t4_drained_valid", 32'(pop_valid),  32'd0);
        check_eq("t4_still_halted",  32'(halted),     32'd1);
        check_eq("t4_still_blocked", 32'(push_ready), 32'd0);

        // 5: flush with halted queue holding 3 entries plus same-cycle push/pop
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("t5_unhalt", 32'(halted), 32'd0);
        push1(16'h4001, 16'h0200);
        push1(16'h4002, 16'h0202);
        push1(16'hF003, 16'h0204);
        check_eq("t5_count3", 32'(count),  32'd3);
        check_eq("t5_halt3",  32'(halted), 32'd1);
        flush      = 1'b1;
        push_valid = 1'b1;
        push_instr = 16'h4444;
        pop_ready  = 1'b1;
        tick();
        flush      = 1'b0;
        push_valid = 1'b0;
        pop_ready  = 1'b0;
        check_eq("t5_count",      32'(count),      32'd0);
        check_eq("t5_pop_valid",  32'(pop_valid),  32'd0);
        check_eq("t5_halted",     32'(halted),     32'd0);
        check_eq("t5_push_ready", 32'(push_ready), 32'd1);
        check_eq("t5_pop_instr",  32'(pop_instr),  32'd0);

        // 5b: flush suppresses a same-cycle HLT push while ready
        push1(16'h5001, 16'h0300);
        flush      = 1'b1;
        push_valid = 1'b1;
        push_instr = 16'hF555;
        tick();
        flush      = 1'b0;
        push_valid = 1'b0;
        check_eq("t5b_count",  32'(count),  32'd0);
        check_eq("t5b_halted", 32'(halted), 32'd0);
        push1(16'h5002, 16'h0302);
        check_eq("t5b_after_flush", 32'(pop_instr), 32'h5002);
        pop1();

        // 6: async reset mid-cycle with 2 entries queued
        push1(16'h6001, 16'h0400);
        push1(16'h6002, 16'h0402);
        check_eq("t6_pre_count", 32'(count), 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_async_count",  32'(count),      32'd0);
        check_eq("t6_async_valid",  32'(pop_valid),  32'd0);
        check_eq("t6_async_instr",  32'(pop_instr),  32'd0);
        check_eq("t6_async_pc",     32'(pop_pc),     32'd0);
        check_eq("t6_async_ready",  32'(push_ready), 32'd1);
        check_eq("t6_async_halted", 32'(halted),     32'd0);
        tick();
        #3;
        rst_n = 1'b1;
        tick();
        check_eq("t6_post_count", 32'(count), 32'd0);
        push1(16'h7001, 16'h0500);
        check_eq("t6_post_push", 32'(pop_instr), 32'h7001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fetch_queue
`default_nettype wire
